// File: rtl/click_classifier_pkg.sv
// Shared types and helpers for the multi-click gesture classifier.
// The FSM state is a plain 1-bit vector so it can be exported on a debug port.
package click_classifier_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_WAIT = 1'b1;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/click_classifier_window_timer.sv
// Gesture window timer: counts idle cycles from a restart and flags the last one.
// The count saturates at WINDOW-1, so it can never wrap while the window is open.
module window_timer
  import click_classifier_pkg::*;
#(
  parameter int WINDOW = 25_000_000,
  localparam int TW = clog2(WINDOW)
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic expire
);

  localparam logic [TW-1:0] LAST = TW'(WINDOW - 1);

  logic [TW-1:0] r_timer;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_timer <= '0;
    end else if (run && !expire) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  assign expire = (r_timer == LAST);

endmodule

// File: rtl/click_classifier.sv
// Groups debounced press pulses into multi-click gestures and emits one
// registered event per gesture carrying its click count.
module click_classifier
  import click_classifier_pkg::*;
#(
  parameter int WINDOW     = 25_000_000,
  parameter int MAX_CLICKS = 3,
  localparam int CW = clog2(MAX_CLICKS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          press,
  output logic          evt_valid,
  output logic [CW-1:0] evt_count,
  output logic          busy,
  output state_t        dbg_state
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_CLICKS);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_evt_valid;
  logic [CW-1:0] r_evt_count;
  logic          r_busy;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_emit;
  logic [CW-1:0] w_emit_cnt;
  logic          w_expire;
  logic          w_restart;
  logic          w_run;

  // Holding the timer in restart while idle means every new gesture starts at 0,
  // and a press in WAIT restarts the window before the timeout is considered.
  assign w_restart = press || (r_state == ST_IDLE);
  assign w_run     = (r_state == ST_WAIT);

  window_timer #(
    .WINDOW (WINDOW)
  ) u_window_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .run     (w_run),
    .expire  (w_expire)
  );

  assign w_cnt_inc = r_cnt + CW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    w_emit_cnt  = r_cnt;
    if (r_state == ST_IDLE) begin
      if (press) begin
        if (MAX_CLICKS == 1) begin
          w_emit     = 1'b1;
          w_emit_cnt = CW'(1);
        end else begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = CW'(1);
        end
      end
    end else begin
      // A press beats a simultaneous timeout: it is counted and the window restarts.
      if (press) begin
        if (w_cnt_inc == MAX_C) begin
          w_emit      = 1'b1;
          w_emit_cnt  = w_cnt_inc;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end else if (w_expire) begin
        w_emit      = 1'b1;
        w_emit_cnt  = r_cnt;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_evt_valid <= 1'b0;
      r_evt_count <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_evt_valid <= w_emit;
      if (w_emit) begin
        r_evt_count <= w_emit_cnt;
      end
      r_busy <= (w_state_nxt == ST_WAIT);
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_count = r_evt_count;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_click_classifier.sv
// Bench for click_classifier (WINDOW=8, MAX_CLICKS=3): each segment resets the DUT,
// replays a press list and compares every cycle against a gesture-level model.
module tb_click_classifier;
  import click_classifier_pkg::*;

  localparam int WINDOW     = 8;
  localparam int MAX_CLICKS = 3;
  localparam int CW         = 2;
  localparam int MAXL       = 160;

  logic          clk;
  logic          rst;
  logic          press;
  logic          evt_valid;
  logic [CW-1:0] evt_count;
  logic          busy;
  state_t        dbg_state;

  int checks = 0;
  int errors = 0;

  // Segment description
  int pq[$];
  int rst_cyc;
  int seg_len;
  bit drv_press[MAXL];

  // Expected per-cycle outputs
  bit            exp_valid[MAXL];
  bit            exp_busy[MAXL];
  logic [CW-1:0] exp_count[MAXL];

  // Model state for the gesture currently open
  bit m_open;
  int m_cnt;
  int m_start;
  int m_last;

  click_classifier #(
    .WINDOW     (WINDOW),
    .MAX_CLICKS (MAX_CLICKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .press     (press),
    .evt_valid (evt_valid),
    .evt_count (evt_count),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Close the open gesture with its event in cycle e.
  task automatic mark_close(input int e);
    if (e < MAXL) begin
      exp_valid[e] = 1'b1;
      for (int k = e; k < MAXL; k++) exp_count[k] = CW'(m_cnt);
    end
    for (int k = m_start + 1; k < e && k < MAXL; k++) exp_busy[k] = 1'b1;
    m_open = 1'b0;
  endtask

  // Reset high in cycle r: an event due by cycle r still appears, otherwise
  // the gesture is dropped and everything reads zero from r+1.
  task automatic model_reset(input int r);
    if (r >= 0) begin
      if (m_open) begin
        if (m_last + WINDOW + 1 <= r) begin
          mark_close(m_last + WINDOW + 1);
        end else begin
          for (int k = m_start + 1; k <= r && k < MAXL; k++) exp_busy[k] = 1'b1;
          m_open = 1'b0;
        end
      end
      for (int k = r + 1; k < MAXL; k++) exp_count[k] = '0;
    end
  endtask

  task automatic build_model();
    bit rdone;
    for (int k = 0; k < MAXL; k++) begin
      exp_valid[k] = 1'b0;
      exp_busy[k]  = 1'b0;
      exp_count[k] = '0;
    end
    m_open = 1'b0;
    m_cnt  = 0;
    rdone  = (rst_cyc < 0);
    foreach (pq[i]) begin
      int p;
      p = pq[i];
      if (!rdone && rst_cyc <= p) begin
        model_reset(rst_cyc);
        rdone = 1'b1;
      end
      if (p == rst_cyc) continue;
      if (m_open && p > m_last + WINDOW) mark_close(m_last + WINDOW + 1);
      if (!m_open) begin
        m_open  = 1'b1;
        m_cnt   = 1;
        m_start = p;
        m_last  = p;
      end else begin
        m_cnt  = m_cnt + 1;
        m_last = p;
      end
      if (m_cnt == MAX_CLICKS) mark_close(p + 1);
    end
    if (!rdone) model_reset(rst_cyc);
    if (m_open) mark_close(m_last + WINDOW + 1);
  endtask

  // Scoreboard comparison for one cycle
  task automatic check_cycle(input string name, input int c);
    state_t exp_state;
    exp_state = exp_busy[c] ? ST_WAIT : ST_IDLE;
    checks++;
    assert (evt_valid === exp_valid[c]) else begin
      errors++;
      $error("FAIL %s evt_valid cycle %0d: got %b want %b", name, c, evt_valid, exp_valid[c]);
    end
    checks++;
    assert (evt_count === exp_count[c]) else begin
      errors++;
      $error("FAIL %s evt_count cycle %0d: got %0d want %0d", name, c, evt_count, exp_count[c]);
    end
    checks++;
    assert (busy === exp_busy[c]) else begin
      errors++;
      $error("FAIL %s busy cycle %0d: got %b want %b", name, c, busy, exp_busy[c]);
    end
    checks++;
    assert (dbg_state === exp_state) else begin
      errors++;
      $error("FAIL %s dbg_state cycle %0d: got %b want %b", name, c, dbg_state, exp_state);
    end
  endtask

  // Driver: reset in cycles 0..2 (plus rst_cyc), presses from pq.
  task automatic run_segment(input string name);
    build_model();
    for (int k = 0; k < MAXL; k++) drv_press[k] = 1'b0;
    foreach (pq[i]) drv_press[pq[i]] = 1'b1;
    for (int c = 0; c < seg_len - 1; c++) begin
      rst   = (c <= 2) || (c == rst_cyc);
      press = drv_press[c];
      @(posedge clk);
      #1;
      check_cycle(name, c + 1);
    end
    rst   = 1'b0;
    press = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    press   = 1'b0;
    seg_len = 50;

    pq = '{10};             rst_cyc = -1; run_segment("single");
    pq = '{10, 15};         rst_cyc = -1; run_segment("double");
    pq = '{10, 12, 14};     rst_cyc = -1; run_segment("triple_limit");
    pq = '{10, 18};         rst_cyc = -1; run_segment("press_at_timeout");
    pq = '{10};             rst_cyc = 13; run_segment("reset_midwindow");
    pq = '{10, 19};         rst_cyc = -1; run_segment("press_on_event");
    pq = '{10, 11, 12, 13}; rst_cyc = -1; run_segment("back_to_back");

    seg_len = 130;
    for (int s = 0; s < 25; s++) begin
      int stride;
      stride = $urandom_range(12, 2);
      pq.delete();
      for (int c = 3; c <= 90; c++) begin
        if ($urandom_range(stride - 1, 0) == 0) pq.push_back(c);
      end
      rst_cyc = ($urandom_range(2, 0) == 0) ? int'($urandom_range(95, 15)) : -1;
      run_segment($sformatf("random%0d", s));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
